// File: rtl/exu_bju_iq_pkg.sv
// ============================================================================
// exu_bju_iq_pkg : shared EXU constants, payload/source types, wakeup helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package exu_bju_iq_pkg;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 3;
  localparam int PREG_W = 6;
  localparam int IID_W  = 5;
  localparam int XLEN   = 64;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct packed {
    logic              vld;
    logic [PREG_W-1:0] preg;
    logic              rdy;
    logic [XLEN-1:0]   value;
  } src_t;

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } payload_t;

  localparam int SRC_W     = $bits(src_t);
  localparam int PAYLOAD_W = $bits(payload_t);

  // Unused sources count as ready; a pending source grabs wb0 before wb1.
  function automatic src_t src_wakeup(
    input src_t              s,
    input logic              wb0_vld,
    input logic [PREG_W-1:0] wb0_preg,
    input logic [XLEN-1:0]   wb0_data,
    input logic              wb1_vld,
    input logic [PREG_W-1:0] wb1_preg,
    input logic [XLEN-1:0]   wb1_data
  );
    src_t r;
    r = s;
    if (!s.vld) begin
      r.rdy = 1'b1;
    end else if (!s.rdy) begin
      if (wb0_vld && (wb0_preg == s.preg)) begin
        r.rdy   = 1'b1;
        r.value = wb0_data;
      end else if (wb1_vld && (wb1_preg == s.preg)) begin
        r.rdy   = 1'b1;
        r.value = wb1_data;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_bju_iq_entry.sv
// ============================================================================
// exu_bju_iq_entry : one issue-queue slot with payload and operand wakeup
// Revision: 1.0
// ============================================================================
`default_nettype none

module exu_bju_iq_entry
  import exu_bju_iq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_clk,
  input  logic                 i_flush,
  input  logic                 i_wr,
  input  logic                 i_pop,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [SRC_W-1:0]     i_src1,
  input  logic [SRC_W-1:0]     i_src2,
  input  logic                 i_wb0_vld,
  input  logic [PREG_W-1:0]    i_wb0_preg,
  input  logic [XLEN-1:0]      i_wb0_data,
  input  logic                 i_wb1_vld,
  input  logic [PREG_W-1:0]    i_wb1_preg,
  input  logic [XLEN-1:0]      i_wb1_data,
  output logic                 o_vld,
  output logic                 o_rdy,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_src1_vld,
  output logic [XLEN-1:0]      o_src1_value,
  output logic                 o_src2_vld,
  output logic [XLEN-1:0]      o_src2_value
);

  logic     r_vld;
  payload_t r_payload;
  src_t     r_src1;
  src_t     r_src2;
  src_t     w_src1_nxt;
  src_t     w_src2_nxt;

  assign w_src1_nxt = src_wakeup(r_src1, i_wb0_vld, i_wb0_preg, i_wb0_data,
                                 i_wb1_vld, i_wb1_preg, i_wb1_data);
  assign w_src2_nxt = src_wakeup(r_src2, i_wb0_vld, i_wb0_preg, i_wb0_data,
                                 i_wb1_vld, i_wb1_preg, i_wb1_data);

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      r_vld     <= 1'b0;
      r_payload <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_wr) begin
      r_vld     <= 1'b1;
      r_payload <= i_payload;
      r_src1    <= i_src1;
      r_src2    <= i_src2;
    end else if (i_pop) begin
      r_vld <= 1'b0;
    end else if (r_vld) begin
      r_src1 <= w_src1_nxt;
      r_src2 <= w_src2_nxt;
    end
  end

  assign o_vld        = r_vld;
  assign o_rdy        = r_vld & r_src1.rdy & r_src2.rdy;
  assign o_payload    = r_payload;
  assign o_src1_vld   = r_src1.vld;
  assign o_src1_value = r_src1.value;
  assign o_src2_vld   = r_src2.vld;
  assign o_src2_value = r_src2.value;

endmodule

`default_nettype wire

// File: rtl/exu_bju_iq.sv
// ============================================================================
// exu_bju_iq : 4-entry in-order issue queue feeding the branch/jump unit
// Optional macro EXU_BJU_IQ_BYPASS_EN: zero-latency issue into an empty queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module exu_bju_iq
  import exu_bju_iq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              dis_iq_vld,
  input  logic [4:0]        dis_iq_iid,
  input  logic [6:0]        dis_iq_opcode,
  input  logic [6:0]        dis_iq_funct7,
  input  logic [2:0]        dis_iq_funct3,
  input  logic [63:0]       dis_iq_pc,
  input  logic              dis_iq_pdst_vld,
  input  logic [5:0]        dis_iq_pdst,
  input  logic              dis_iq_imm_vld,
  input  logic [63:0]       dis_iq_imm,
  input  logic              dis_iq_psrc1_vld,
  input  logic [5:0]        dis_iq_psrc1_preg,
  input  logic              dis_iq_psrc1_rdy,
  input  logic [63:0]       dis_iq_psrc1_value,
  input  logic              dis_iq_psrc2_vld,
  input  logic [5:0]        dis_iq_psrc2_preg,
  input  logic              dis_iq_psrc2_rdy,
  input  logic [63:0]       dis_iq_psrc2_value,
  output logic              iq_dis_full,
  input  logic              exu_iq_wb0_vld,
  input  logic [5:0]        exu_iq_wb0_preg,
  input  logic [63:0]       exu_iq_wb0_data,
  input  logic              exu_iq_wb1_vld,
  input  logic [5:0]        exu_iq_wb1_preg,
  input  logic [63:0]       exu_iq_wb1_data,
  output logic              idu_exu_bju_vld,
  output logic [4:0]        idu_exu_bju_iid,
  output logic [6:0]        idu_exu_bju_opcode,
  output logic [6:0]        idu_exu_bju_funct7,
  output logic [2:0]        idu_exu_bju_funct3,
  output logic [63:0]       idu_exu_bju_pc,
  output logic              idu_exu_bju_psrc1_vld,
  output logic [63:0]       idu_exu_bju_psrc1_value,
  output logic              idu_exu_bju_psrc2_vld,
  output logic [63:0]       idu_exu_bju_psrc2_value,
  output logic              idu_exu_bju_pdst_vld,
  output logic [5:0]        idu_exu_bju_pdst,
  output logic              idu_exu_bju_imm_vld,
  output logic [63:0]       idu_exu_bju_imm
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic                 w_ent_vld     [DEPTH];
  logic                 w_ent_rdy     [DEPTH];
  logic [PAYLOAD_W-1:0] w_ent_payload [DEPTH];
  logic                 w_ent_s1_vld  [DEPTH];
  logic [XLEN-1:0]      w_ent_s1_val  [DEPTH];
  logic                 w_ent_s2_vld  [DEPTH];
  logic [XLEN-1:0]      w_ent_s2_val  [DEPTH];

  payload_t w_dis_payload;
  src_t     w_dis_src1;
  src_t     w_dis_src2;
  payload_t w_head_payload;
  payload_t w_out_payload;
  logic     w_out_s1_vld;
  logic     w_out_s2_vld;
  logic [XLEN-1:0] w_out_s1_val;
  logic [XLEN-1:0] w_out_s2_val;

  logic w_full;
  logic w_enq_req;
  logic w_enq;
  logic w_q_issue;
  logic w_bypass;
  logic w_unused_head_vld;

  assign w_dis_payload = {dis_iq_iid, dis_iq_opcode, dis_iq_funct7, dis_iq_funct3,
                          dis_iq_pc, dis_iq_pdst_vld, dis_iq_pdst,
                          dis_iq_imm_vld, dis_iq_imm};

  // A wakeup landing in the dispatch cycle is folded in before the write.
  assign w_dis_src1 = src_wakeup({dis_iq_psrc1_vld, dis_iq_psrc1_preg,
                                  dis_iq_psrc1_rdy, dis_iq_psrc1_value},
                                 exu_iq_wb0_vld, exu_iq_wb0_preg, exu_iq_wb0_data,
                                 exu_iq_wb1_vld, exu_iq_wb1_preg, exu_iq_wb1_data);
  assign w_dis_src2 = src_wakeup({dis_iq_psrc2_vld, dis_iq_psrc2_preg,
                                  dis_iq_psrc2_rdy, dis_iq_psrc2_value},
                                 exu_iq_wb0_vld, exu_iq_wb0_preg, exu_iq_wb0_data,
                                 exu_iq_wb1_vld, exu_iq_wb1_preg, exu_iq_wb1_data);

  assign w_full     = (r_count == FULL_CNT) & ~rst_clk;
  assign w_enq_req  = dis_iq_vld & ~w_full & ~rtu_global_flush & ~rst_clk;
  assign w_head_payload    = w_ent_payload[r_head];
  assign w_unused_head_vld = w_ent_vld[r_head];
  assign w_q_issue  = w_ent_rdy[r_head] & ~rtu_global_flush & ~rst_clk;

`ifdef EXU_BJU_IQ_BYPASS_EN
  assign w_bypass = w_enq_req & (r_count == 3'd0) & w_dis_src1.rdy & w_dis_src2.rdy;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq = w_enq_req & ~w_bypass;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    exu_bju_iq_entry u_entry (
      .clk          (clk),
      .rst_clk      (rst_clk),
      .i_flush      (rtu_global_flush),
      .i_wr         (w_enq & (r_tail == PTR_W'(gi))),
      .i_pop        (w_q_issue & (r_head == PTR_W'(gi))),
      .i_payload    (w_dis_payload),
      .i_src1       (w_dis_src1),
      .i_src2       (w_dis_src2),
      .i_wb0_vld    (exu_iq_wb0_vld),
      .i_wb0_preg   (exu_iq_wb0_preg),
      .i_wb0_data   (exu_iq_wb0_data),
      .i_wb1_vld    (exu_iq_wb1_vld),
      .i_wb1_preg   (exu_iq_wb1_preg),
      .i_wb1_data   (exu_iq_wb1_data),
      .o_vld        (w_ent_vld[gi]),
      .o_rdy        (w_ent_rdy[gi]),
      .o_payload    (w_ent_payload[gi]),
      .o_src1_vld   (w_ent_s1_vld[gi]),
      .o_src1_value (w_ent_s1_val[gi]),
      .o_src2_vld   (w_ent_s2_vld[gi]),
      .o_src2_value (w_ent_s2_val[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_clk || rtu_global_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 2'd1;
      end
      if (w_q_issue) begin
        r_head <= r_head + 2'd1;
      end
      case ({w_enq, w_q_issue})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_out_payload = '0;
    w_out_s1_vld  = 1'b0;
    w_out_s1_val  = '0;
    w_out_s2_vld  = 1'b0;
    w_out_s2_val  = '0;
    if (w_q_issue) begin
      w_out_payload = w_head_payload;
      w_out_s1_vld  = w_ent_s1_vld[r_head];
      w_out_s1_val  = w_ent_s1_val[r_head];
      w_out_s2_vld  = w_ent_s2_vld[r_head];
      w_out_s2_val  = w_ent_s2_val[r_head];
    end else if (w_bypass) begin
      w_out_payload = w_dis_payload;
      w_out_s1_vld  = w_dis_src1.vld;
      w_out_s1_val  = w_dis_src1.value;
      w_out_s2_vld  = w_dis_src2.vld;
      w_out_s2_val  = w_dis_src2.value;
    end
  end

  assign iq_dis_full             = w_full;
  assign idu_exu_bju_vld         = w_q_issue | w_bypass;
  assign idu_exu_bju_iid         = w_out_payload.iid;
  assign idu_exu_bju_opcode      = w_out_payload.opcode;
  assign idu_exu_bju_funct7      = w_out_payload.funct7;
  assign idu_exu_bju_funct3      = w_out_payload.funct3;
  assign idu_exu_bju_pc          = w_out_payload.pc;
  assign idu_exu_bju_psrc1_vld   = w_out_s1_vld;
  assign idu_exu_bju_psrc1_value = w_out_s1_val;
  assign idu_exu_bju_psrc2_vld   = w_out_s2_vld;
  assign idu_exu_bju_psrc2_value = w_out_s2_val;
  assign idu_exu_bju_pdst_vld    = w_out_payload.pdst_vld;
  assign idu_exu_bju_pdst        = w_out_payload.pdst;
  assign idu_exu_bju_imm_vld     = w_out_payload.imm_vld;
  assign idu_exu_bju_imm         = w_out_payload.imm;

endmodule

`default_nettype wire

// File: tb/tb_exu_bju_iq.sv
// ============================================================================
// tb_exu_bju_iq : directed scenarios plus randomized run against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exu_bju_iq;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int OBS_W = 289;

  logic        clk = 1'b0;
  logic        rst_clk, rtu_global_flush, dis_iq_vld;
  logic [4:0]  dis_iq_iid;
  logic [6:0]  dis_iq_opcode, dis_iq_funct7;
  logic [2:0]  dis_iq_funct3;
  logic [63:0] dis_iq_pc, dis_iq_imm;
  logic        dis_iq_pdst_vld, dis_iq_imm_vld;
  logic [5:0]  dis_iq_pdst;
  logic        dis_iq_psrc1_vld, dis_iq_psrc1_rdy, dis_iq_psrc2_vld, dis_iq_psrc2_rdy;
  logic [5:0]  dis_iq_psrc1_preg, dis_iq_psrc2_preg;
  logic [63:0] dis_iq_psrc1_value, dis_iq_psrc2_value;
  logic        iq_dis_full;
  logic        exu_iq_wb0_vld, exu_iq_wb1_vld;
  logic [5:0]  exu_iq_wb0_preg, exu_iq_wb1_preg;
  logic [63:0] exu_iq_wb0_data, exu_iq_wb1_data;
  logic        idu_exu_bju_vld;
  logic [4:0]  idu_exu_bju_iid;
  logic [6:0]  idu_exu_bju_opcode, idu_exu_bju_funct7;
  logic [2:0]  idu_exu_bju_funct3;
  logic [63:0] idu_exu_bju_pc, idu_exu_bju_psrc1_value, idu_exu_bju_psrc2_value, idu_exu_bju_imm;
  logic        idu_exu_bju_psrc1_vld, idu_exu_bju_psrc2_vld, idu_exu_bju_pdst_vld, idu_exu_bju_imm_vld;
  logic [5:0]  idu_exu_bju_pdst;
  logic [OBS_W-1:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_bju_iq dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
    .dis_iq_vld(dis_iq_vld), .dis_iq_iid(dis_iq_iid), .dis_iq_opcode(dis_iq_opcode),
    .dis_iq_funct7(dis_iq_funct7), .dis_iq_funct3(dis_iq_funct3), .dis_iq_pc(dis_iq_pc),
    .dis_iq_pdst_vld(dis_iq_pdst_vld), .dis_iq_pdst(dis_iq_pdst),
    .dis_iq_imm_vld(dis_iq_imm_vld), .dis_iq_imm(dis_iq_imm),
    .dis_iq_psrc1_vld(dis_iq_psrc1_vld), .dis_iq_psrc1_preg(dis_iq_psrc1_preg),
    .dis_iq_psrc1_rdy(dis_iq_psrc1_rdy), .dis_iq_psrc1_value(dis_iq_psrc1_value),
    .dis_iq_psrc2_vld(dis_iq_psrc2_vld), .dis_iq_psrc2_preg(dis_iq_psrc2_preg),
    .dis_iq_psrc2_rdy(dis_iq_psrc2_rdy), .dis_iq_psrc2_value(dis_iq_psrc2_value),
    .iq_dis_full(iq_dis_full),
    .exu_iq_wb0_vld(exu_iq_wb0_vld), .exu_iq_wb0_preg(exu_iq_wb0_preg), .exu_iq_wb0_data(exu_iq_wb0_data),
    .exu_iq_wb1_vld(exu_iq_wb1_vld), .exu_iq_wb1_preg(exu_iq_wb1_preg), .exu_iq_wb1_data(exu_iq_wb1_data),
    .idu_exu_bju_vld(idu_exu_bju_vld), .idu_exu_bju_iid(idu_exu_bju_iid),
    .idu_exu_bju_opcode(idu_exu_bju_opcode), .idu_exu_bju_funct7(idu_exu_bju_funct7),
    .idu_exu_bju_funct3(idu_exu_bju_funct3), .idu_exu_bju_pc(idu_exu_bju_pc),
    .idu_exu_bju_psrc1_vld(idu_exu_bju_psrc1_vld), .idu_exu_bju_psrc1_value(idu_exu_bju_psrc1_value),
    .idu_exu_bju_psrc2_vld(idu_exu_bju_psrc2_vld), .idu_exu_bju_psrc2_value(idu_exu_bju_psrc2_value),
    .idu_exu_bju_pdst_vld(idu_exu_bju_pdst_vld), .idu_exu_bju_pdst(idu_exu_bju_pdst),
    .idu_exu_bju_imm_vld(idu_exu_bju_imm_vld), .idu_exu_bju_imm(idu_exu_bju_imm)
  );

  assign obs = {idu_exu_bju_vld, idu_exu_bju_iid, idu_exu_bju_opcode, idu_exu_bju_funct7,
                idu_exu_bju_funct3, idu_exu_bju_pc, idu_exu_bju_psrc1_vld, idu_exu_bju_psrc1_value,
                idu_exu_bju_psrc2_vld, idu_exu_bju_psrc2_value, idu_exu_bju_pdst_vld,
                idu_exu_bju_pdst, idu_exu_bju_imm_vld, idu_exu_bju_imm};

  // Reference model: queue of pending instructions, oldest first.
  typedef struct {
    logic [4:0] iid; logic [6:0] opcode; logic [6:0] f7; logic [2:0] f3; logic [63:0] pc;
    logic dv; logic [5:0] pdst; logic iv; logic [63:0] imm;
    logic s1v; logic [5:0] s1p; logic s1r; logic [63:0] s1x;
    logic s2v; logic [5:0] s2p; logic s2r; logic [63:0] s2x;
  } ent_t;
  ent_t mq[$];

  function automatic logic [OBS_W-1:0] pack_exp(ent_t e);
    return {1'b1, e.iid, e.opcode, e.f7, e.f3, e.pc, e.s1v, e.s1x, e.s2v, e.s2x,
            e.dv, e.pdst, e.iv, e.imm};
  endfunction

  // A source becomes ready if unused, already ready, or named by a result bus (wb0 first).
  function automatic ent_t wake_ent(ent_t e);
    ent_t r = e;
    if (!r.s1v) r.s1r = 1'b1;
    else if (!r.s1r && exu_iq_wb0_vld && exu_iq_wb0_preg == r.s1p) begin r.s1r = 1'b1; r.s1x = exu_iq_wb0_data; end
    else if (!r.s1r && exu_iq_wb1_vld && exu_iq_wb1_preg == r.s1p) begin r.s1r = 1'b1; r.s1x = exu_iq_wb1_data; end
    if (!r.s2v) r.s2r = 1'b1;
    else if (!r.s2r && exu_iq_wb0_vld && exu_iq_wb0_preg == r.s2p) begin r.s2r = 1'b1; r.s2x = exu_iq_wb0_data; end
    else if (!r.s2r && exu_iq_wb1_vld && exu_iq_wb1_preg == r.s2p) begin r.s2r = 1'b1; r.s2x = exu_iq_wb1_data; end
    return r;
  endfunction

  function automatic ent_t dis_ent();
    ent_t e;
    e.iid = dis_iq_iid; e.opcode = dis_iq_opcode; e.f7 = dis_iq_funct7; e.f3 = dis_iq_funct3;
    e.pc = dis_iq_pc; e.dv = dis_iq_pdst_vld; e.pdst = dis_iq_pdst; e.iv = dis_iq_imm_vld; e.imm = dis_iq_imm;
    e.s1v = dis_iq_psrc1_vld; e.s1p = dis_iq_psrc1_preg; e.s1r = dis_iq_psrc1_rdy; e.s1x = dis_iq_psrc1_value;
    e.s2v = dis_iq_psrc2_vld; e.s2p = dis_iq_psrc2_preg; e.s2r = dis_iq_psrc2_rdy; e.s2x = dis_iq_psrc2_value;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rtu_global_flush = 1'b0; dis_iq_vld = 1'b0; dis_iq_iid = '0; dis_iq_opcode = '0;
    dis_iq_funct7 = '0; dis_iq_funct3 = '0; dis_iq_pc = '0; dis_iq_pdst_vld = 1'b0;
    dis_iq_pdst = '0; dis_iq_imm_vld = 1'b0; dis_iq_imm = '0;
    dis_iq_psrc1_vld = 1'b0; dis_iq_psrc1_preg = '0; dis_iq_psrc1_rdy = 1'b0; dis_iq_psrc1_value = '0;
    dis_iq_psrc2_vld = 1'b0; dis_iq_psrc2_preg = '0; dis_iq_psrc2_rdy = 1'b0; dis_iq_psrc2_value = '0;
    exu_iq_wb0_vld = 1'b0; exu_iq_wb0_preg = '0; exu_iq_wb0_data = '0;
    exu_iq_wb1_vld = 1'b0; exu_iq_wb1_preg = '0; exu_iq_wb1_data = '0;
  endtask

  task automatic drive_dis(input logic [4:0] iid, input logic [6:0] op,
                           input logic s1v, input logic [5:0] s1p, input logic s1r, input logic [63:0] s1x,
                           input logic s2v, input logic [5:0] s2p, input logic s2r, input logic [63:0] s2x);
    dis_iq_vld = 1'b1; dis_iq_iid = iid; dis_iq_opcode = op; dis_iq_pc = 64'h8000_0000 + 64'(iid) * 4;
    dis_iq_psrc1_vld = s1v; dis_iq_psrc1_preg = s1p; dis_iq_psrc1_rdy = s1r; dis_iq_psrc1_value = s1x;
    dis_iq_psrc2_vld = s2v; dis_iq_psrc2_preg = s2p; dis_iq_psrc2_rdy = s2r; dis_iq_psrc2_value = s2x;
  endtask

  task automatic test_reset();
    rst_clk = 1'b1; idle();
    drive_dis(5'd2, OP_JAL, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    step(); step(); #2;
    checks++; if ({iq_dis_full, obs} !== '0) begin failures++;
      $display("FAIL reset_during: full=%b out=%h expected all zero", iq_dis_full, obs); end
    step(); rst_clk = 1'b0; idle(); #2;
    checks++; if ({iq_dis_full, obs} !== '0) begin failures++;
      $display("FAIL reset_after: full=%b out=%h expected all zero", iq_dis_full, obs); end
  endtask

  task automatic test_jal();
    step(); drive_dis(5'd3, OP_JAL, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++;
      $display("FAIL jal_no_same_cycle: vld=%b expected 0", idu_exu_bju_vld); end
    step(); idle(); #2;
    checks++; if ({idu_exu_bju_vld, idu_exu_bju_iid, idu_exu_bju_opcode} !== {1'b1, 5'd3, OP_JAL}) begin failures++;
      $display("FAIL jal_issue: vld/iid/op=%b/%0d/%h expected 1/3/%h", idu_exu_bju_vld, idu_exu_bju_iid, idu_exu_bju_opcode, OP_JAL); end
    step(); #2;
    checks++; if ({iq_dis_full, obs} !== '0) begin failures++;
      $display("FAIL jal_drained: full=%b out=%h expected all zero", iq_dis_full, obs); end
  endtask

  task automatic test_wakeup();
    step(); drive_dis(5'd7, OP_BRANCH, 1'b1, 6'd9, 1'b0, 64'd0, 1'b1, 6'd10, 1'b1, 64'h22); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL beq_c0: vld=%b expected 0", idu_exu_bju_vld); end
    step(); idle(); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL beq_c1: vld=%b expected 0", idu_exu_bju_vld); end
    step(); exu_iq_wb1_vld = 1'b1; exu_iq_wb1_preg = 6'd9; exu_iq_wb1_data = 64'h55; #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL beq_c2: vld=%b expected 0", idu_exu_bju_vld); end
    step(); idle(); #2;
    checks++; if ({idu_exu_bju_vld, idu_exu_bju_iid, idu_exu_bju_psrc1_value, idu_exu_bju_psrc2_value} !==
                  {1'b1, 5'd7, 64'h55, 64'h22}) begin failures++;
      $display("FAIL beq_c3: vld=%b iid=%0d s1=%h s2=%h expected 1 7 55 22", idu_exu_bju_vld,
               idu_exu_bju_iid, idu_exu_bju_psrc1_value, idu_exu_bju_psrc2_value); end
    step(); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL beq_c4: vld=%b expected 0", idu_exu_bju_vld); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      step(); idle();
      drive_dis(5'(10 + k), OP_BRANCH, (k == 0), 6'd20, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0); #2;
      checks++; if ({idu_exu_bju_vld, iq_dis_full} !== 2'b00) begin failures++;
        $display("FAIL fill_%0d: vld=%b full=%b expected 0 0", k, idu_exu_bju_vld, iq_dis_full); end
    end
    step(); idle(); drive_dis(5'd14, OP_JALR, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0); #2;
    checks++; if (iq_dis_full !== 1'b1) begin failures++; $display("FAIL full_at_4: full=%b expected 1", iq_dis_full); end
    step(); idle(); exu_iq_wb0_vld = 1'b1; exu_iq_wb0_preg = 6'd20; exu_iq_wb0_data = 64'h99; #2;
    checks++; if ({idu_exu_bju_vld, iq_dis_full} !== 2'b01) begin failures++;
      $display("FAIL full_wake: vld=%b full=%b expected 0 1", idu_exu_bju_vld, iq_dis_full); end
    for (int k = 0; k < 4; k++) begin
      step(); idle(); #2;
      checks++; if ({idu_exu_bju_vld, idu_exu_bju_iid, iq_dis_full} !== {1'b1, 5'(10 + k), (k == 0)}) begin failures++;
        $display("FAIL drain_%0d: vld=%b iid=%0d full=%b expected 1 %0d %b", k, idu_exu_bju_vld,
                 idu_exu_bju_iid, iq_dis_full, 10 + k, (k == 0)); end
    end
    step(); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL fifth_dropped: vld=%b expected 0", idu_exu_bju_vld); end
  endtask

  task automatic test_dual_wb();
    step(); drive_dis(5'd1, OP_BRANCH, 1'b1, 6'd12, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    step(); idle();
    exu_iq_wb0_vld = 1'b1; exu_iq_wb0_preg = 6'd12; exu_iq_wb0_data = 64'hA;
    exu_iq_wb1_vld = 1'b1; exu_iq_wb1_preg = 6'd12; exu_iq_wb1_data = 64'hB; #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL dual_wb_wait: vld=%b expected 0", idu_exu_bju_vld); end
    step(); idle(); #2;
    checks++; if ({idu_exu_bju_vld, idu_exu_bju_psrc1_value} !== {1'b1, 64'hA}) begin failures++;
      $display("FAIL dual_wb_prio: vld=%b s1=%h expected 1 a", idu_exu_bju_vld, idu_exu_bju_psrc1_value); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      step(); idle(); drive_dis(5'(20 + k), OP_BRANCH, 1'b1, 6'd30, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    end
    step(); idle(); rtu_global_flush = 1'b1;
    drive_dis(5'd23, OP_JAL, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    exu_iq_wb0_vld = 1'b1; exu_iq_wb0_preg = 6'd30; exu_iq_wb0_data = 64'h1; #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL flush_cycle: vld=%b expected 0", idu_exu_bju_vld); end
    step(); idle(); exu_iq_wb0_vld = 1'b1; exu_iq_wb0_preg = 6'd30; #2;
    checks++; if ({idu_exu_bju_vld, iq_dis_full} !== 2'b00) begin failures++;
      $display("FAIL flush_after: vld=%b full=%b expected 0 0", idu_exu_bju_vld, iq_dis_full); end
    step(); idle(); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL flush_empty: vld=%b expected 0", idu_exu_bju_vld); end
    for (int k = 0; k < 4; k++) begin
      step(); idle(); drive_dis(5'(24 + k), OP_BRANCH, 1'b1, 6'd31, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0); #2;
      checks++; if (iq_dis_full !== 1'b0) begin failures++; $display("FAIL refill_%0d: full=%b expected 0", k, iq_dis_full); end
    end
    step(); idle(); #2;
    checks++; if (iq_dis_full !== 1'b1) begin failures++; $display("FAIL refill_full: full=%b expected 1", iq_dis_full); end
    rtu_global_flush = 1'b1; step(); idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      step(); idle();
      if (k < 6) drive_dis(5'(k), OP_JAL, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
      #2;
      checks++;
      if ({idu_exu_bju_vld, idu_exu_bju_iid, iq_dis_full} !== {(k > 0), (k > 0) ? 5'(k - 1) : 5'd0, 1'b0}) begin
        failures++;
        $display("FAIL b2b_%0d: vld=%b iid=%0d full=%b expected %b %0d 0", k, idu_exu_bju_vld,
                 idu_exu_bju_iid, iq_dis_full, (k > 0), (k > 0) ? k - 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      step(); idle(); drive_dis(5'(k + 16), OP_JAL, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    end
    step(); rst_clk = 1'b1; exu_iq_wb0_vld = 1'b1; #2;
    checks++; if ({iq_dis_full, obs} !== '0) begin failures++;
      $display("FAIL reset_mid: full=%b out=%h expected all zero", iq_dis_full, obs); end
    step(); rst_clk = 1'b0; idle(); #2;
    checks++; if (idu_exu_bju_vld !== 1'b0) begin failures++; $display("FAIL reset_mid_empty: vld=%b expected 0", idu_exu_bju_vld); end
  endtask

  task automatic test_random();
    logic [4:0] iid_ctr = 5'd0;
    logic exp_vld, exp_full;
    logic [OBS_W-1:0] exp_obs;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      step(); idle();
      rtu_global_flush = ($urandom_range(0, 39) == 0);
      dis_iq_vld = ($urandom_range(0, 2) != 0);
      dis_iq_iid = iid_ctr; dis_iq_opcode = ($urandom_range(0, 1) != 0) ? OP_BRANCH : OP_JALR;
      dis_iq_funct7 = 7'($urandom); dis_iq_funct3 = 3'($urandom); dis_iq_pc = {$urandom, $urandom};
      dis_iq_pdst_vld = 1'($urandom); dis_iq_pdst = 6'($urandom);
      dis_iq_imm_vld = 1'($urandom); dis_iq_imm = {$urandom, $urandom};
      dis_iq_psrc1_vld = 1'($urandom); dis_iq_psrc1_preg = 6'($urandom_range(1, 6));
      dis_iq_psrc1_rdy = ($urandom_range(0, 2) == 0); dis_iq_psrc1_value = {$urandom, $urandom};
      dis_iq_psrc2_vld = 1'($urandom); dis_iq_psrc2_preg = 6'($urandom_range(1, 6));
      dis_iq_psrc2_rdy = ($urandom_range(0, 2) == 0); dis_iq_psrc2_value = {$urandom, $urandom};
      exu_iq_wb0_vld = ($urandom_range(0, 2) == 0); exu_iq_wb0_preg = 6'($urandom_range(1, 6));
      exu_iq_wb0_data = {$urandom, $urandom};
      exu_iq_wb1_vld = ($urandom_range(0, 2) == 0); exu_iq_wb1_preg = 6'($urandom_range(1, 6));
      exu_iq_wb1_data = {$urandom, $urandom};
      #2;
      exp_full = (mq.size() == 4);
      exp_vld  = !rtu_global_flush && mq.size() > 0 && mq[0].s1r && mq[0].s2r;
      exp_obs  = exp_vld ? pack_exp(mq[0]) : '0;
      checks++; if (iq_dis_full !== exp_full) begin failures++;
        $display("FAIL rand_full cyc=%0d: full=%b expected %b", cyc, iq_dis_full, exp_full); end
      checks++; if (obs !== exp_obs) begin failures++;
        $display("FAIL rand_issue cyc=%0d: out=%h expected %h", cyc, obs, exp_obs); end
      if (rtu_global_flush) begin
        mq.delete();
      end else begin
        foreach (mq[i]) mq[i] = wake_ent(mq[i]);
        if (exp_vld) void'(mq.pop_front());
        if (dis_iq_vld && !exp_full) begin
          mq.push_back(wake_ent(dis_ent()));
          iid_ctr = iid_ctr + 5'd1;
        end
      end
    end
  endtask

  initial begin
    rst_clk = 1'b1;
    idle();
    test_reset();
    test_jal();
    test_wakeup();
    test_full();
    test_dual_wb();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exu_bju_iq.md
EXU_BJU_IQ -- requirements
Module: exu_bju_iq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have ports: rst_clk  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: rtu_global_flush  in  1  discard all queued and issuing work.
REQ-004 SHALL have ports: dis_iq_vld  in  1  dispatch enqueue request.
REQ-005 SHALL have ports: dis_iq_{iid 5, opcode 7, funct7 7, funct3 3, pc 64, pdst_vld 1, pdst 6, imm_vld 1, imm 64}  in  instruction payload.
REQ-006 SHALL have ports: dis_iq_psrcN_{vld 1, preg 6, rdy 1, value 64} (N=1,2)  in  source operand and its ready/value at dispatch.
REQ-007 SHALL have ports: iq_dis_full  out  1  queue cannot accept.
REQ-008 SHALL have ports: exu_iq_wbM_{vld 1, preg 6, data 64} (M=0,1)  in  two result-wakeup buses.
REQ-009 SHALL have ports: idu_exu_bju_vld  out  1, plus idu_exu_bju_{iid, opcode, funct7, funct3, pc, psrc1_vld, psrc1_value, psrc2_vld, psrc2_value, pdst_vld, pdst, imm_vld, imm}  out  widths as dispatch payload; issue to BJU.
REQ-010 SHALL use constant DEPTH = 4 (entries) and PREG_W = 6.

Function
REQ-011 SHALL be an in-order circular queue: 2-bit head/tail pointers wrapping 3->0, 3-bit count 0..4.
REQ-012 SHALL assert iq_dis_full combinationally when count == 4; full SHALL NOT consider a same-cycle issue.
REQ-013 SHALL enqueue at tail when dis_iq_vld & ~iq_dis_full & ~rtu_global_flush; otherwise the request SHALL be ignored with no state change.
REQ-014 SHALL mark a source ready when psrcN_vld == 0, or psrcN_rdy == 1, or a wakeup matches it in the enqueue cycle.
REQ-015 SHALL, each cycle, for every valid entry's unready source where exu_iq_wbM_vld & (wbM_preg == psrcN_preg), capture wbM_data and set ready next edge; wb0 wins if both buses match.
REQ-016 SHALL issue only the head entry, and only when it is valid with both sources ready; at most one issue per cycle.
REQ-017 SHALL drive idu_exu_bju_vld and payload combinationally from the head entry in the issue cycle, popping head at that edge; payload SHALL be all-zero when idu_exu_bju_vld == 0.
REQ-018 SHALL, on simultaneous enqueue and issue, advance both pointers with count unchanged.
REQ-019 SHALL give minimum enqueue-to-issue latency of 1 cycle (enqueue edge N, vld high in cycle N+1) without bypass.
REQ-020 SHALL block issue of younger entries while head is unready (no out-of-order issue).
REQ-021 SHALL, while rtu_global_flush is high, drive idu_exu_bju_vld = 0 and clear all entries, pointers and count at the edge; wakeups that cycle are dropped.

Reset
REQ-022 SHALL, when rst_clk is high at posedge, clear all entry valid/ready bits, head = tail = 0, count = 0.
REQ-023 SHALL hold iq_dis_full = 0 and idu_exu_bju_vld = 0 with zero payload during and after reset.
REQ-024 SHALL give reset priority over flush, enqueue, wakeup and issue when asserted mid-operation.

Configuration
REQ-025 SHALL, with EXU_BJU_IQ_BYPASS_EN defined, issue a dispatched instruction in the same cycle (no storage) when count == 0 and both sources are ready per REQ-014; latency 0.
REQ-026 SHALL, without EXU_BJU_IQ_BYPASS_EN, always write the entry into the queue; latency per REQ-019.

Structure
REQ-027 SHALL take DEPTH, PREG_W, IID_W and the BJU opcode constants (JAL, JALR, BRANCH) from the shared EXU package.
REQ-028 SHALL instantiate one sub-module exu_bju_iq_entry per slot, holding payload, source ready bits and wakeup compare/capture.

Verification
REQ-029 SHALL cover: enqueue JAL iid=3, both srcs vld=0 -> vld=1 with iid=3 next cycle (same cycle with bypass), count back to 0.
REQ-030 SHALL cover: enqueue BEQ psrc1 preg=9 not ready; wb1 preg=9 data=0x55 at cycle+2 -> issue at cycle+3 with psrc1_value=0x55.
REQ-031 SHALL cover: 4 enqueues with unready head -> full=1, 5th dis_iq_vld dropped; head wakes -> 4 issues in iids order over 4 cycles.
REQ-032 SHALL cover: wb0 and wb1 both preg=12, data 0xA/0xB -> captured value 0xA.
REQ-033 SHALL cover: flush with 3 entries plus same-cycle enqueue -> vld=0 that cycle, count=0, full=0 next cycle.
REQ-034 SHALL cover: pointer wrap, 6 enqueue/issue pairs back-to-back -> issue order matches iids 0..5, count never exceeds 1.
